// File: rtl/ifmap_byte_fifo_pkg.sv
// fifo_pkg: push-mode encodings and word geometry shared by the ifmap byte FIFO files
package fifo_pkg;
  localparam logic PUSH_BYTE = 1'b0;
  localparam logic PUSH_WORD = 1'b1;
  localparam int BYTES_PER_WORD = 4;
endpackage

// File: rtl/ifmap_byte_fifo_if.sv
// ifmap_byte_fifo_if: controller (master) to byte FIFO (slave) push/pop and status bundle
interface ifmap_byte_fifo_if import fifo_pkg::*; #(parameter int DEPTH = 8);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  logic fifo_reset;
  logic push;
  logic push_mod;
  logic [8*BYTES_PER_WORD-1:0] push_data;
  logic pop;
  logic [7:0] pop_data;
  logic full;
  logic empty;
  logic free_ge4;
  logic [CNT_W-1:0] count;
  logic overflow;
  logic underflow;
  modport master(
    output fifo_reset, push, push_mod, push_data, pop,
    input pop_data, full, empty, free_ge4, count, overflow, underflow
  );
  modport slave(
    input fifo_reset, push, push_mod, push_data, pop,
    output pop_data, full, empty, free_ge4, count, overflow, underflow
  );
endinterface

// File: rtl/ifmap_byte_fifo_ram.sv
// fifo_byte_ram: DEPTH x 8 byte storage, four independently addressed write lanes, one async read port
module fifo_byte_ram import fifo_pkg::*; #(
  parameter int DEPTH = 8,
  localparam int PW = $clog2(DEPTH)
) (
  input  logic clk,
  input  logic [BYTES_PER_WORD-1:0] we,
  input  logic [BYTES_PER_WORD-1:0][PW-1:0] waddr,
  input  logic [BYTES_PER_WORD-1:0][7:0] wdata,
  input  logic [PW-1:0] raddr,
  output logic [7:0] rdata
);
  logic [7:0] mem [DEPTH];
  // lane writes; lanes of one word push always target distinct addresses
  always_ff @(posedge clk)
    for (int k = 0; k < BYTES_PER_WORD; k++)
      if (we[k]) mem[waddr[k]] <= wdata[k];
  assign rdata = mem[raddr];
endmodule

// File: rtl/ifmap_byte_fifo.sv
// ifmap_byte_fifo: byte/word push, byte pop FIFO feeding one PE row; IFMAP_FIFO_ERR_EN enables sticky overflow/underflow
module ifmap_byte_fifo import fifo_pkg::*; #(
  parameter int DEPTH = 8
) (
  input logic clk,
  input logic rst_n,
  ifmap_byte_fifo_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CNT_W = PW + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] WORD_C = CNT_W'(BYTES_PER_WORD);
  logic [PW-1:0] wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
  logic [CNT_W-1:0] count, count_n, free, push_n;
  logic pop_ok, byte_ok, word_ok;
  logic [BYTES_PER_WORD-1:0] we;
  logic [BYTES_PER_WORD-1:0][PW-1:0] waddr;
  logic [7:0] rdata;
  // accept decisions and next pointer/count; a same-cycle pop frees one slot for the push
  always_comb begin
    free = DEPTH_C - count;
    pop_ok = bus.pop && count != '0;
    byte_ok = bus.push && bus.push_mod == PUSH_BYTE && (count != DEPTH_C || pop_ok);
    word_ok = bus.push && bus.push_mod == PUSH_WORD && (free >= WORD_C || (free >= WORD_C - 1'b1 && pop_ok));
    push_n = word_ok ? WORD_C : CNT_W'(byte_ok);
    count_n = count + push_n - CNT_W'(pop_ok);
    wr_ptr_n = wr_ptr + push_n[PW-1:0];
    rd_ptr_n = rd_ptr + PW'(pop_ok);
    for (int k = 0; k < BYTES_PER_WORD; k++) begin
      we[k] = word_ok || (k == 0 && byte_ok);
      waddr[k] = wr_ptr + PW'(k);
    end
  end
  // pointer and occupancy registers; controller clear overrides any same-cycle traffic
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else if (bus.fifo_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr_n;
      rd_ptr <= rd_ptr_n;
      count <= count_n;
    end
  fifo_byte_ram #(.DEPTH(DEPTH)) u_ram (
    .clk(clk),
    .we(we),
    .waddr(waddr),
    .wdata(bus.push_data),
    .raddr(rd_ptr),
    .rdata(rdata)
  );
  assign bus.count = count;
  assign bus.full = count == DEPTH_C;
  assign bus.empty = count == '0;
  assign bus.free_ge4 = free >= WORD_C;
  assign bus.pop_data = count == '0 ? 8'h00 : rdata;
`ifdef IFMAP_FIFO_ERR_EN
  logic overflow, underflow;
  // sticky error capture, cleared only by reset or controller clear
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      overflow <= 1'b0;
      underflow <= 1'b0;
    end else if (bus.fifo_reset) begin
      overflow <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (bus.push && !(byte_ok || word_ok)) begin
        overflow <= 1'b1;
        $error("ifmap_byte_fifo: push rejected (count=%0d)", count);
      end
      if (bus.pop && count == '0) begin
        underflow <= 1'b1;
        $error("ifmap_byte_fifo: pop while empty");
      end
    end
  assign bus.overflow = overflow;
  assign bus.underflow = underflow;
`else
  assign bus.overflow = 1'b0;
  assign bus.underflow = 1'b0;
`endif
endmodule

// File: tb/tb_ifmap_byte_fifo.sv
// tb_ifmap_byte_fifo: directed stimulus with a byte scoreboard checked by a pop monitor
module tb_ifmap_byte_fifo;
  import fifo_pkg::*;
`ifdef IFMAP_FIFO_ERR_EN
  localparam logic ERR = 1'b1;
`else
  localparam logic ERR = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  logic [7:0] exp_q[$];
  always #5 clk = ~clk;
  ifmap_byte_fifo_if #(.DEPTH(8)) bus();
  ifmap_byte_fifo #(.DEPTH(8)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", name, got, exp);
    end
  endtask
  task automatic cyc(input logic rs, input logic push, input logic mode, input logic [31:0] d, input logic pop, input logic acc);
    @(posedge clk);
    #1;
    bus.fifo_reset = rs;
    bus.push = push;
    bus.push_mod = mode;
    bus.push_data = d;
    bus.pop = pop;
    if (rs) exp_q.delete();
    else if (push && acc)
      for (int i = 0; i < (mode ? BYTES_PER_WORD : 1); i++) exp_q.push_back(d[8*i +: 8]);
  endtask
  task automatic state(input string name, input logic [3:0] cnt, input logic f, input logic e, input logic g);
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    chk({name, ".count"}, bus.count, cnt);
    chk({name, ".full"}, bus.full, f);
    chk({name, ".empty"}, bus.empty, e);
    chk({name, ".free_ge4"}, bus.free_ge4, g);
  endtask
  task automatic pops(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
  endtask
  always @(negedge clk)
    if (rst_n && bus.pop && !bus.fifo_reset) begin
      if (!bus.empty) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL pop_extra: got=%0h exp=none", bus.pop_data);
        end else chk("pop_data", bus.pop_data, exp_q.pop_front());
      end else if (exp_q.size() != 0) begin
        total++;
        bad++;
        $display("FAIL pop_empty: got=empty exp=%0h", exp_q[0]);
      end
    end
  initial begin
    bus.fifo_reset = 1'b0;
    bus.push = 1'b0;
    bus.push_mod = 1'b0;
    bus.push_data = '0;
    bus.pop = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.count", bus.count, 0);
    chk("rst.empty", bus.empty, 1);
    chk("rst.full", bus.full, 0);
    chk("rst.free_ge4", bus.free_ge4, 1);
    chk("rst.pop_data", bus.pop_data, 0);
    chk("rst.overflow", bus.overflow, 0);
    chk("rst.underflow", bus.underflow, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, PUSH_BYTE, 32'h11 + i, 1'b0, 1'b1);
    state("fill8", 8, 1, 0, 0);
    cyc(1'b0, 1'b1, PUSH_BYTE, 32'h77, 1'b0, 1'b0);
    state("full_rej", 8, 1, 0, 0);
    pops(8);
    state("drain8", 0, 0, 1, 1);
    chk("drain8.pop_data", bus.pop_data, 0);
    cyc(1'b0, 1'b1, PUSH_WORD, 32'hDDCCBBAA, 1'b0, 1'b1);
    state("word", 4, 0, 0, 1);
    pops(4);
    state("word_drain", 0, 0, 1, 1);
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, PUSH_BYTE, 32'h21 + i, 1'b0, 1'b1);
    state("cnt6", 6, 0, 0, 0);
    cyc(1'b0, 1'b1, PUSH_WORD, 32'h44332211, 1'b0, 1'b0);
    state("word_rej", 6, 0, 0, 0);
    chk("word_rej.overflow", bus.overflow, ERR);
    pops(1);
    state("cnt5", 5, 0, 0, 0);
    cyc(1'b0, 1'b1, PUSH_WORD, 32'hCAFEF00D, 1'b0, 1'b0);
    state("free3_rej", 5, 0, 0, 0);
    cyc(1'b0, 1'b1, PUSH_WORD, 32'h88776655, 1'b1, 1'b1);
    state("word_pop_wrap", 8, 1, 0, 0);
    cyc(1'b0, 1'b1, PUSH_BYTE, 32'h99, 1'b1, 1'b1);
    state("full_byte_pop", 8, 1, 0, 0);
    pops(8);
    state("drain_wrap", 0, 0, 1, 1);
    pops(1);
    state("empty_pop", 0, 0, 1, 1);
    chk("empty_pop.underflow", bus.underflow, ERR);
    cyc(1'b0, 1'b1, PUSH_BYTE, 32'h31, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, PUSH_BYTE, 32'h32, 1'b0, 1'b1);
    state("cnt2", 2, 0, 0, 1);
    cyc(1'b1, 1'b1, PUSH_BYTE, 32'h33, 1'b0, 1'b0);
    state("frst", 0, 0, 1, 1);
    chk("frst.overflow", bus.overflow, 0);
    chk("frst.underflow", bus.underflow, 0);
    chk("frst.pop_data", bus.pop_data, 0);
    cyc(1'b0, 1'b1, PUSH_BYTE, 32'h41, 1'b0, 1'b1);
    state("latency", 1, 0, 0, 1);
    chk("latency.pop_data", bus.pop_data, 32'h41);
    pops(1);
    state("final", 0, 0, 1, 1);
    chk("final.queue", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
